// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/arb_2x1_rr_if.sv
// Requester/grant bundle between two bus masters and the shared-resource arbiter.
interface arb_2x1_rr_if #(parameter int W = 8);
  // Request/grant contract: a requester raises req_k and holds it for as long as
  // it wants the resource; it owns the resource in every cycle gnt_k is high and
  // releases it by dropping req_k (the grant falls on the next edge).
  logic         req0;
  logic         req1;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [W-1:0] dout;
  logic         busy;

  modport master (output req0, req1, din0, din1,
                  input  gnt0, gnt1, sel, dout, busy);
  modport slave  (input  req0, req1, din0, din1,
                  output gnt0, gnt1, sel, dout, busy);
endinterface

// File: rtl/mux2_bus.sv
// W-bit 2:1 datapath mux for the shared sink.
module mux2_bus #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  output logic [W-1:0] dout
);
  assign dout = sel ? din1 : din0;
endmodule

// File: rtl/arb_2x1_rr.sv
// Two-requester round-robin arbiter driving a shared W-bit 2:1 mux.
// Optional burst limit is enabled with the ARB_BURST_LIMIT_EN macro.
module arb_2x1_rr
  import arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         reset,
  arb_2x1_rr_if.slave  bus,
  output arb_state_t   state_dbg,
  output logic         last_dbg
);
  arb_state_t state;
  arb_state_t next_state;
  logic       sel_q;
  logic       last_q;
  logic       other_req;
  logic       preempt;

  always_comb begin
    other_req = 1'b0;
    case (state)
      GNT0:    other_req = bus.req1;
      GNT1:    other_req = bus.req0;
      default: other_req = 1'b0;
    endcase
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt;

  assign preempt = other_req && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Counts cycles the non-owner has waited; restarts on every ownership change.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (next_state != state) begin
      hold_cnt <= '0;
    end else if (other_req && (hold_cnt != '1)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  logic unused_max_hold;
  assign preempt         = 1'b0;
  assign unused_max_hold = (MAX_HOLD < 2);
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) next_state = (last_q == REQ0) ? GNT1 : GNT0;
        else if (bus.req0)        next_state = GNT0;
        else if (bus.req1)        next_state = GNT1;
        else                      next_state = IDLE;
      end
      // Releasing owner hands straight to a waiting peer, no idle bubble.
      GNT0: if (!bus.req0 || preempt) next_state = bus.req1 ? GNT1 : IDLE;
      GNT1: if (!bus.req1 || preempt) next_state = bus.req0 ? GNT0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // sel and last only move on entry to a grant state; IDLE keeps both.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel_q  <= REQ0;
      last_q <= REQ1;
    end else begin
      state <= next_state;
      if (next_state == GNT0) begin
        sel_q  <= REQ0;
        last_q <= REQ0;
      end else if (next_state == GNT1) begin
        sel_q  <= REQ1;
        last_q <= REQ1;
      end
    end
  end

  assign bus.gnt0  = (state == GNT0);
  assign bus.gnt1  = (state == GNT1);
  assign bus.sel   = sel_q;
  assign bus.busy  = bus.gnt0 | bus.gnt1;
  assign state_dbg = state;
  assign last_dbg  = last_q;

  mux2_bus #(.W(W)) u_mux (
    .sel  (sel_q),
    .din0 (bus.din0),
    .din1 (bus.din1),
    .dout (bus.dout)
  );
endmodule

// File: tb/tb_arb_2x1_rr.sv
// Self-checking bench for arb_2x1_rr: directed scenarios plus random traffic
// against an owner/last/wait-count reference model.
module tb_arb_2x1_rr;
  import arb_pkg::*;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
  localparam int EW       = W + 6;

  logic       clk;
  logic       reset;
  arb_state_t state_dbg;
  logic       last_dbg;

  arb_2x1_rr_if #(.W(W)) bus ();

  arb_2x1_rr #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg),
    .last_dbg  (last_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // reference model: owner -1 = nobody, 0/1 = requester index
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;
  int m_wait  = 0;

  logic [EW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic r0, input logic r1);
    int nxt;
    int oth;
    bit mine;
    bit theirs;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_last = 1; m_wait = 0;
      return;
    end
    nxt    = m_owner;
    oth    = 1 - m_owner;
    mine   = (m_owner == 0) ? r0 : r1;
    theirs = (m_owner == 0) ? r1 : r0;
    if (m_owner < 0) begin
      if (r0 && r1)  nxt = 1 - m_last;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
    end else if (!mine) begin
      nxt = theirs ? oth : -1;
    end
`ifdef ARB_BURST_LIMIT_EN
    else if (theirs && m_wait == MAX_HOLD - 1) begin
      nxt = oth;
    end
`endif
    if (nxt != m_owner)         m_wait = 0;
    else if (nxt >= 0 && theirs) m_wait++;
    if (nxt >= 0) begin
      m_sel  = nxt;
      m_last = nxt;
    end
    m_owner = nxt;
  endtask

  // driver: apply inputs, predict post-edge outputs, sample #1 after the edge
  task automatic step(input logic rst, input logic r0, input logic r1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1, input string tag);
    logic [EW-1:0] e;
    arb_state_t    est;
    logic [W-1:0]  edout;
    reset    = rst;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.din0 = d0;
    bus.din1 = d1;
    model_edge(rst, r0, r1);
    est   = (m_owner == 0) ? GNT0 : (m_owner == 1) ? GNT1 : IDLE;
    edout = (m_sel == 1) ? d1 : d0;
    exp_q.push_back({(m_owner == 0), (m_owner == 1), m_sel[0], m_last[0], est, edout});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".gnt0"},  W'(bus.gnt0),  W'(e[W+5]));
    chk({tag, ".gnt1"},  W'(bus.gnt1),  W'(e[W+4]));
    chk({tag, ".sel"},   W'(bus.sel),   W'(e[W+3]));
    chk({tag, ".last"},  W'(last_dbg),  W'(e[W+2]));
    chk({tag, ".state"}, W'(state_dbg), W'(e[W+1:W]));
    chk({tag, ".dout"},  bus.dout,      e[W-1:0]);
    chk({tag, ".busy"},  W'(bus.busy),  W'(e[W+5] | e[W+4]));
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!(bus.gnt0 && bus.gnt1)) else begin
      failures++;
      $error("FAIL mutex got=%b%b exp=not_both", bus.gnt0, bus.gnt1);
    end
  end

  initial begin
    int alt_exp;
    int first_gnt1;
    int held;
    logic r0, r1;
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;

    // reset with both requesters active
    step(1, 1, 1, 8'h3C, 8'hC3, "rst_a");
    step(1, 1, 1, 8'h3C, 8'hC3, "rst_b");
    chk("rst_dout_din0", bus.dout, 8'h3C);
    step(0, 1, 1, 8'h3C, 8'hC3, "rst_rel");
    chk("rst_rel_gnt0", W'(bus.gnt0), 8'd1);

    // single request from idle
    step(0, 0, 0, 8'h11, 8'h22, "idle");
    step(0, 0, 1, 8'h11, 8'hA5, "single");
    chk("single_dout", bus.dout, 8'hA5);
    step(0, 0, 0, 8'h11, 8'hA5, "single_rel");
    chk("single_rel_sel", W'(bus.sel), 8'd1);

    // tie alternation: the current owner drops its request each cycle
    step(0, 1, 1, 8'h01, 8'h02, "tie_start");
    alt_exp = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, m_owner != 0, m_owner != 1, 8'($urandom), 8'($urandom), "tie");
      chk("tie_alt", W'(bus.gnt1), W'(alt_exp));
      chk("tie_no_idle", W'(bus.busy), 8'd1);
      alt_exp = 1 - alt_exp;
    end

    // back-to-back handover
    step(0, 0, 0, 8'h00, 8'h00, "ho_idle");
    step(0, 1, 0, 8'h5A, 8'hA5, "ho_g0");
    step(0, 1, 1, 8'h5A, 8'hA5, "ho_wait");
    step(0, 0, 1, 8'h5A, 8'hA5, "ho_swap");
    chk("ho_gnt1", W'(bus.gnt1), 8'd1);

    // burst: req0 held, req1 raised while GNT0 owns
    step(0, 0, 0, 8'h00, 8'h00, "bu_idle");
    step(0, 1, 0, 8'h77, 8'h88, "bu_g0");
    first_gnt1 = 0;
    held       = 0;
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, 1, 8'h77, 8'h88, "burst");
      if (bus.gnt0) held++;
      if (bus.gnt1 && first_gnt1 == 0) first_gnt1 = i;
    end
`ifdef ARB_BURST_LIMIT_EN
    chk("burst_wait", W'(first_gnt1), 8'd4);
`else
    chk("no_burst_hold", W'(held), 8'd100);
`endif

    // reset in the middle of a GNT1 grant
    step(0, 0, 0, 8'h00, 8'h00, "mr_idle");
    step(0, 0, 1, 8'h12, 8'h34, "mr_g1");
    step(1, 1, 1, 8'h12, 8'h34, "mid_rst");
    chk("mid_rst_gnt1", W'(bus.gnt1), 8'd0);
    chk("mid_rst_last", W'(last_dbg), 8'd1);
    step(0, 1, 1, 8'h12, 8'h34, "mr_after");
    chk("mr_after_gnt0", W'(bus.gnt0), 8'd1);

    // random traffic, requests tend to persist
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      step($urandom_range(0, 49) == 0, r0, r1, 8'($urandom), 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
